// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between the ALU (A)
// and load/mul-div (B) writeback paths. It also provides read-hazard flags and a stall counter.
module regfile_wb_arbiter #(
    parameter int rnum_width = 5,
    parameter int data_width = 32,
    parameter int cnt_width  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [rnum_width-1:0] a_rd,
    input  logic [data_width-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [rnum_width-1:0] b_rd,
    input  logic [data_width-1:0] b_data,
    output logic                  b_ready,
    output logic [rnum_width-1:0] rd,
    output logic [data_width-1:0] data,
    output logic                  write,
    input  logic [rnum_width-1:0] q_r1,
    input  logic [rnum_width-1:0] q_r2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [cnt_width-1:0]  stall_count
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e                 prio_q, prio_d;
    logic                  write_q, write_d;
    logic [rnum_width-1:0] rd_q, rd_d;
    logic [data_width-1:0] data_q, data_d;
    logic [cnt_width-1:0]  stall_count_q, stall_count_d;

    logic                  grant;
    logic                  stall;
    logic [rnum_width-1:0] grant_rd;
    logic [data_width-1:0] grant_data;

    // While reset is high, no request is granted. When both sides are valid, the pointer decides.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            if (a_valid && (!b_valid || prio_q == PRIO_A)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    always_comb begin
        grant      = a_ready || b_ready;
        grant_rd   = b_ready ? b_rd   : a_rd;
        grant_data = b_ready ? b_data : a_data;
        stall      = (a_valid && !a_ready) || (b_valid && !b_ready);

        prio_d        = prio_q;
        write_d       = 1'b0;
        rd_d          = rd_q;
        data_d        = data_q;
        stall_count_d = stall_count_q;

        if (a_ready) begin
            prio_d = PRIO_B;
        end else if (b_ready) begin
            prio_d = PRIO_A;
        end

        // Writes to $zero are accepted but never reach the register file.
        if (grant && grant_rd != '0) begin
            write_d = 1'b1;
            rd_d    = grant_rd;
            data_d  = grant_data;
        end

        if (stall && stall_count_q != {cnt_width{1'b1}}) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q        <= PRIO_A;
            write_q       <= 1'b0;
            rd_q          <= '0;
            data_q        <= '0;
            stall_count_q <= '0;
        end else begin
            prio_q        <= prio_d;
            write_q       <= write_d;
            rd_q          <= rd_d;
            data_q        <= data_d;
            stall_count_q <= stall_count_d;
        end
    end

    // A register is in flight if it is requested by either side or sits in the output stage.
    always_comb begin
        hazard1 = (q_r1 != '0) && ((a_valid && a_rd == q_r1) ||
                                   (b_valid && b_rd == q_r1) ||
                                   (write_q && rd_q == q_r1));
        hazard2 = (q_r2 != '0) && ((a_valid && a_rd == q_r2) ||
                                   (b_valid && b_rd == q_r2) ||
                                   (write_q && rd_q == q_r2));
    end

    assign write       = write_q;
    assign rd          = rd_q;
    assign data        = data_q;
    assign stall_count = stall_count_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rd/data/write) between two writeback requesters:
  - A: ALU writeback.
  - B: load / multiply-divide writeback.
- Uses valid/ready handshakes, round-robin arbitration and one registered output stage.
- Provides combinational read-hazard flags for the two register-file read ports and a saturating stall counter for performance monitoring.
- Sits between the pipeline writeback stage and the register file. The register file commits on the falling edge of the cycle in which write is high.

Parameters:
- rnum_width, 5: register-number width (32 registers).
- data_width, 32: register data width.
- cnt_width, 16: stall-counter width.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  requester A has a write pending
- a_rd  in  rnum_width  requester A destination register
- a_data  in  data_width  requester A write data
- a_ready  out  1  A granted this cycle (combinational)
- b_valid  in  1  requester B has a write pending
- b_rd  in  rnum_width  requester B destination register
- b_data  in  data_width  requester B write data
- b_ready  out  1  B granted this cycle (combinational)
- rd  out  rnum_width  register-file write address (registered)
- data  out  data_width  register-file write data (registered)
- write  out  1  register-file write enable (registered)
- q_r1  in  rnum_width  read-port 1 register number (hazard query)
- q_r2  in  rnum_width  read-port 2 register number (hazard query)
- hazard1  out  1  q_r1 has a write in flight
- hazard2  out  1  q_r2 has a write in flight
- stall_count  out  cnt_width  saturating count of requester-stall cycles

Behaviour:
- Reset (reset=1 at rising edge):
  - write=0, rd=0, data=0, stall_count=0, priority pointer=A.
  - While reset is high, a_ready=b_ready=0 and no grant occurs.
  - Reset mid-operation discards any un-granted request and any write in the output stage; write is 0 in the cycle after the reset edge.
- Handshake:
  - A transfer occurs on a rising edge where valid&&ready.
  - A requester holding valid must keep rd/data stable until ready.
  - ready never depends on the requester's own ready; valid may depend on nothing from this block.
- Arbitration (combinational, at most one grant per cycle):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the side named by the pointer.
- Pointer: on any grant, updates to the non-granted side. With no grant, it holds.
  - Consequence: a continuously valid requester is granted within 2 cycles.
- Output stage (no backpressure; the register file always accepts):
  - On a grant with rd_in≠0: next cycle write=1, rd/data = granted values.
  - On a grant with rd_in=0: request is accepted (ready=1, pointer updates) but next cycle write=0 and rd/data hold. Writes to $zero are discarded.
  - No grant: next cycle write=0, rd/data hold.
- Latency: grant at edge N → write high during cycle N+1 → register file commits at the falling edge of cycle N+1.
- Same rd from both requesters: writes leave in grant order; the later grant's data is final.
- Hazard (combinational): hazard1=1 iff q_r1≠0 and any of the following holds (hazard2 identical for q_r2):
  - a_valid && a_rd==q_r1
  - b_valid && b_rd==q_r1
  - write && rd==q_r1
- stall_count: increments by 1 per cycle where (a_valid&&!a_ready) or (b_valid&&!b_ready), at most +1 per cycle. It saturates at all-ones and never wraps.
- All outputs are X-free from the first cycle after reset.

Test Plan:
- Reset, then A only: a_valid=1, a_rd=3, a_data=0x1234 → a_ready=1 same cycle; next cycle write=1, rd=3, data=0x1234; following cycle write=0.
- Both valid, held for 4 cycles (A rd=1 data=0xA, B rd=2 data=0xB, requesters reissue after grant) → grants A,B,A,B; write stream rd=1,2,1,2; stall_count=4.
- $zero discard: b_valid=1, b_rd=0, data=0xFFFFFFFF → b_ready=1; next cycle write=0, rd/data unchanged; pointer now favours A (verify with a simultaneous request next cycle → A granted).
- Hazard: a_valid=1, a_rd=5, q_r1=5, q_r2=0 → hazard1=1, hazard2=0. One cycle after the grant → hazard1=1 via the output stage. Two cycles after → hazard1=0.
- Saturation: cnt_width overridden to 3; hold B stalled by constant contention for 10 cycles → stall_count reaches 7 and stays 7.
- Reset mid-operation: assert reset in the cycle after a grant (write would be 1) → after the edge write=0, stall_count=0, pointer=A. During reset a_ready=b_ready=0 despite valid=1.
